matrix_route_ctrl: RTL and testbench

- Control-side writer for the audio routing crossbar: owns the eleven 4-bit source selectors that steer the nine audio sources onto the eleven sinks.
- Accepts route commands from the CPU/config bus over a valid/ready handshake and stages them in shadow registers.
- Commits all staged routes atomically on an audio sample tick, so a patch change never splits across a sample.
- Sits between the config register decoder and the crossbar's sel_out1..sel_out11 inputs.

---
 rtl/matrix_route_ctrl_pkg.sv | 25 ++
 rtl/matrix_route_ctrl_sel_bank.sv | 60 ++++++
 rtl/matrix_route_ctrl.sv | 160 ++++++++++++++++
 tb/tb_matrix_route_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_route_ctrl_pkg.sv
// Shared definitions for the audio routing matrix control path:
// command opcodes, controller state encoding and the mute source code.
package matrix_route_ctrl_pkg;

  localparam int NUM_IN_DEF  = 9;
  localparam int NUM_OUT_DEF = 11;
  localparam int SELW_DEF    = 4;

  // Source code 0 routes silence to a sink.
  localparam logic [SELW_DEF-1:0] MUTE_SRC = '0;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_COMMIT = 2'b10,
    OP_READ   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WAIT_TICK = 2'b01,
    ST_RESP      = 2'b10
  } state_e;

endpackage

// File: rtl/matrix_route_ctrl_sel_bank.sv
// Shadow and active selector register array. Shadow entries are staged by
// write/clear; all active entries copy their shadow in a single commit.
// Sink indices are 1-based; index 0 and indices above NUM_OUT address nothing.
module matrix_sel_bank
  import matrix_route_ctrl_pkg::*;
#(
  parameter int NUM_OUT = NUM_OUT_DEF,
  parameter int SELW    = SELW_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wr_en,
  input  logic [SELW-1:0]         wr_idx,
  input  logic [SELW-1:0]         wr_src,
  input  logic                    clr_en,
  input  logic                    commit_en,
  input  logic [SELW-1:0]         rd_idx,
  output logic [SELW-1:0]         rd_data,
  output logic [NUM_OUT*SELW-1:0] active_flat
);

  logic [SELW-1:0] shadow [1:NUM_OUT];
  logic [SELW-1:0] active [1:NUM_OUT];

  // Shadow staging: clear wins over a write in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 1; i <= NUM_OUT; i++) shadow[i] <= SELW'(MUTE_SRC);
    end else if (clr_en) begin
      for (int i = 1; i <= NUM_OUT; i++) shadow[i] <= SELW'(MUTE_SRC);
    end else if (wr_en) begin
      for (int i = 1; i <= NUM_OUT; i++)
        if (wr_idx == SELW'(i)) shadow[i] <= wr_src;
    end
  end

  // Active selectors move only on commit, all in the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 1; i <= NUM_OUT; i++) active[i] <= SELW'(MUTE_SRC);
    end else if (commit_en) begin
      for (int i = 1; i <= NUM_OUT; i++) active[i] <= shadow[i];
    end
  end

  // Shadow readback; an index that names no sink reads as 0.
  always_comb begin
    rd_data = '0;
    for (int i = 1; i <= NUM_OUT; i++)
      if (rd_idx == SELW'(i)) rd_data = shadow[i];
  end

  // Flatten active selectors for the top level, sink 1 in the low bits.
  always_comb begin
    active_flat = '0;
    for (int i = 1; i <= NUM_OUT; i++)
      active_flat[(i-1)*SELW +: SELW] = active[i];
  end

endmodule

// File: rtl/matrix_route_ctrl.sv
// Route command front end for the audio crossbar. Takes WRITE/CLEAR/READ/COMMIT
// over valid/ready, stages routes in the shadow bank and commits them all on the
// first sample tick after a COMMIT, so a patch change never splits a sample.
// Every command returns exactly one response held until rsp_ready.
module matrix_route_ctrl
  import matrix_route_ctrl_pkg::*;
#(
  parameter int NUM_IN  = NUM_IN_DEF,
  parameter int NUM_OUT = NUM_OUT_DEF,
  parameter int SELW    = SELW_DEF
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [SELW-1:0] cmd_idx,
  input  logic [SELW-1:0] cmd_src,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [SELW-1:0] rsp_data,
  output logic            rsp_err,
  input  logic            sample_tick,
  output logic            commit_done,
  output logic [SELW-1:0] sel_out1,
  output logic [SELW-1:0] sel_out2,
  output logic [SELW-1:0] sel_out3,
  output logic [SELW-1:0] sel_out4,
  output logic [SELW-1:0] sel_out5,
  output logic [SELW-1:0] sel_out6,
  output logic [SELW-1:0] sel_out7,
  output logic [SELW-1:0] sel_out8,
  output logic [SELW-1:0] sel_out9,
  output logic [SELW-1:0] sel_out10,
  output logic [SELW-1:0] sel_out11
);

  state_e                  state, state_nxt;
  logic                    idx_ok, src_ok;
  logic                    wr_en, clr_en, commit_en;
  logic                    load_rsp, clr_rsp;
  logic [SELW-1:0]         rsp_data_nxt;
  logic                    rsp_err_nxt;
  logic [SELW-1:0]         rd_data;
  logic [NUM_OUT*SELW-1:0] active_flat;

  assign idx_ok    = (cmd_idx != '0) && (cmd_idx <= SELW'(NUM_OUT));
  assign src_ok    = (cmd_src <= SELW'(NUM_IN));
  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  matrix_sel_bank #(
    .NUM_OUT (NUM_OUT),
    .SELW    (SELW)
  ) u_bank (
    .clk         (clk),
    .resetn      (resetn),
    .wr_en       (wr_en),
    .wr_idx      (cmd_idx),
    .wr_src      (cmd_src),
    .clr_en      (clr_en),
    .commit_en   (commit_en),
    .rd_idx      (cmd_idx),
    .rd_data     (rd_data),
    .active_flat (active_flat)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state, bank strobes and response capture. cmd_ready equals IDLE, so a
  // valid command seen in IDLE is an accepted one. Ticks outside WAIT_TICK are
  // ignored, which also drops a tick coincident with COMMIT acceptance.
  always_comb begin
    state_nxt    = state;
    wr_en        = 1'b0;
    clr_en       = 1'b0;
    commit_en    = 1'b0;
    load_rsp     = 1'b0;
    clr_rsp      = 1'b0;
    rsp_data_nxt = '0;
    rsp_err_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_WRITE: begin
              wr_en       = idx_ok && src_ok;
              rsp_err_nxt = !(idx_ok && src_ok);
              load_rsp    = 1'b1;
              state_nxt   = ST_RESP;
            end
            OP_CLEAR: begin
              clr_en    = 1'b1;
              load_rsp  = 1'b1;
              state_nxt = ST_RESP;
            end
            OP_READ: begin
              rsp_data_nxt = rd_data;
              rsp_err_nxt  = !idx_ok;
              load_rsp     = 1'b1;
              state_nxt    = ST_RESP;
            end
            default: state_nxt = ST_WAIT_TICK;
          endcase
        end
      end
      ST_WAIT_TICK: begin
        if (sample_tick) begin
          commit_en = 1'b1;
          load_rsp  = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          clr_rsp   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Response payload, held steady for the whole RESP state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (load_rsp) begin
      rsp_data <= rsp_data_nxt;
      rsp_err  <= rsp_err_nxt;
    end else if (clr_rsp) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end
  end

  // One-cycle pulse aligned with the active selector update.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) commit_done <= 1'b0;
    else         commit_done <= commit_en;
  end

  assign sel_out1  = active_flat[ 0*SELW +: SELW];
  assign sel_out2  = active_flat[ 1*SELW +: SELW];
  assign sel_out3  = active_flat[ 2*SELW +: SELW];
  assign sel_out4  = active_flat[ 3*SELW +: SELW];
  assign sel_out5  = active_flat[ 4*SELW +: SELW];
  assign sel_out6  = active_flat[ 5*SELW +: SELW];
  assign sel_out7  = active_flat[ 6*SELW +: SELW];
  assign sel_out8  = active_flat[ 7*SELW +: SELW];
  assign sel_out9  = active_flat[ 8*SELW +: SELW];
  assign sel_out10 = active_flat[ 9*SELW +: SELW];
  assign sel_out11 = active_flat[10*SELW +: SELW];

endmodule

// File: tb/tb_matrix_route_ctrl.sv
// Bench for matrix_route_ctrl: vector table, directed corner sequences and a
// randomized run against a behavioural model of the routing matrix.
module tb_matrix_route_ctrl;
  import matrix_route_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_idx, cmd_src;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic       sample_tick, commit_done;
  logic [3:0] sel_out1, sel_out2, sel_out3, sel_out4, sel_out5, sel_out6;
  logic [3:0] sel_out7, sel_out8, sel_out9, sel_out10, sel_out11;
  logic [3:0] sel [1:11];

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: staged and live route per sink.
  int m_shadow [1:11];
  int m_active [1:11];

  typedef struct {
    logic [1:0] op;
    logic [3:0] idx;
    logic [3:0] src;
    logic [3:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t tbl [18];

  always #5 clk = ~clk;

  matrix_route_ctrl dut (
    .clk         (clk),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_idx     (cmd_idx),
    .cmd_src     (cmd_src),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .sample_tick (sample_tick),
    .commit_done (commit_done),
    .sel_out1    (sel_out1),
    .sel_out2    (sel_out2),
    .sel_out3    (sel_out3),
    .sel_out4    (sel_out4),
    .sel_out5    (sel_out5),
    .sel_out6    (sel_out6),
    .sel_out7    (sel_out7),
    .sel_out8    (sel_out8),
    .sel_out9    (sel_out9),
    .sel_out10   (sel_out10),
    .sel_out11   (sel_out11)
  );

  assign sel[1]  = sel_out1;
  assign sel[2]  = sel_out2;
  assign sel[3]  = sel_out3;
  assign sel[4]  = sel_out4;
  assign sel[5]  = sel_out5;
  assign sel[6]  = sel_out6;
  assign sel[7]  = sel_out7;
  assign sel[8]  = sel_out8;
  assign sel[9]  = sel_out9;
  assign sel[10] = sel_out10;
  assign sel[11] = sel_out11;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_sel(input string nm);
    for (int i = 1; i <= 11; i++)
      chk($sformatf("%s_sel_out%0d", nm, i), int'(sel[i]), m_active[i]);
  endtask

  task automatic model_reset();
    for (int i = 1; i <= 11; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
  endtask

  // Issue one command from IDLE, check it against the model through to the
  // response handshake. For COMMIT, tick_dly idle cycles pass before the tick.
  task automatic run_cmd(input logic [1:0] op, input int idx, input int src,
                         input int tick_dly, input bit tick_at_accept,
                         input int rsp_dly, output int got_data, output int got_err);
    int  exp_data;
    int  exp_err;
    bit  legal_idx;
    legal_idx = (idx >= 1) && (idx <= 11);
    exp_data  = 0;
    exp_err   = 0;
    chk("cmd_ready_idle", int'(cmd_ready), 1);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_idx     = idx[3:0];
    cmd_src     = src[3:0];
    sample_tick = tick_at_accept;
    @(posedge clk); #1;
    cmd_valid   = 1'b0;
    sample_tick = 1'b0;
    case (op)
      OP_WRITE: begin
        if (legal_idx && src >= 0 && src <= 9) m_shadow[idx] = src;
        else exp_err = 1;
      end
      OP_CLEAR: for (int i = 1; i <= 11; i++) m_shadow[i] = 0;
      OP_READ: begin
        if (legal_idx) exp_data = m_shadow[idx];
        else exp_err = 1;
      end
      default: begin
        chk("commit_done_at_accept", int'(commit_done), 0);
        chk("rsp_valid_at_accept", int'(rsp_valid), 0);
        chk_sel("accept");
        for (int c = 0; c < tick_dly; c++) begin
          chk("cmd_ready_wait", int'(cmd_ready), 0);
          chk("rsp_valid_wait", int'(rsp_valid), 0);
          chk("commit_done_wait", int'(commit_done), 0);
          @(posedge clk); #1;
        end
        chk_sel("pre_tick");
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        for (int i = 1; i <= 11; i++) m_active[i] = m_shadow[i];
        chk("commit_done_pulse", int'(commit_done), 1);
        chk_sel("commit");
      end
    endcase
    chk("rsp_valid_rise", int'(rsp_valid), 1);
    chk("rsp_data", int'(rsp_data), exp_data);
    chk("rsp_err", int'(rsp_err), exp_err);
    got_data = int'(rsp_data);
    got_err  = int'(rsp_err);
    for (int c = 0; c < rsp_dly; c++) begin
      sample_tick = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("rsp_valid_hold", int'(rsp_valid), 1);
      chk("rsp_data_hold", int'(rsp_data), exp_data);
      chk("rsp_err_hold", int'(rsp_err), exp_err);
      chk("cmd_ready_busy", int'(cmd_ready), 0);
      chk("commit_done_single", int'(commit_done), 0);
    end
    sample_tick = 1'b0;
    rsp_ready   = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", int'(rsp_valid), 0);
    chk("cmd_ready_back", int'(cmd_ready), 1);
    chk("commit_done_after", int'(commit_done), 0);
    chk_sel("after_rsp");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gd, ge;
    int r_op, r_idx, r_src;

    tbl[0]  = '{OP_WRITE, 4'd3,  4'd7,  4'd0, 1'b0};
    tbl[1]  = '{OP_READ,  4'd3,  4'd0,  4'd7, 1'b0};
    tbl[2]  = '{OP_WRITE, 4'd0,  4'd1,  4'd0, 1'b1};
    tbl[3]  = '{OP_WRITE, 4'd12, 4'd1,  4'd0, 1'b1};
    tbl[4]  = '{OP_WRITE, 4'd2,  4'd10, 4'd0, 1'b1};
    tbl[5]  = '{OP_READ,  4'd0,  4'd0,  4'd0, 1'b1};
    tbl[6]  = '{OP_READ,  4'd12, 4'd0,  4'd0, 1'b1};
    tbl[7]  = '{OP_WRITE, 4'd11, 4'd9,  4'd0, 1'b0};
    tbl[8]  = '{OP_READ,  4'd11, 4'd0,  4'd9, 1'b0};
    tbl[9]  = '{OP_WRITE, 4'd5,  4'd15, 4'd0, 1'b1};
    tbl[10] = '{OP_READ,  4'd5,  4'd0,  4'd0, 1'b0};
    tbl[11] = '{OP_CLEAR, 4'd0,  4'd0,  4'd0, 1'b0};
    tbl[12] = '{OP_READ,  4'd3,  4'd0,  4'd0, 1'b0};
    tbl[13] = '{OP_READ,  4'd11, 4'd0,  4'd0, 1'b0};
    tbl[14] = '{OP_WRITE, 4'd3,  4'd7,  4'd0, 1'b0};
    tbl[15] = '{OP_WRITE, 4'd11, 4'd9,  4'd0, 1'b0};
    tbl[16] = '{OP_WRITE, 4'd1,  4'd0,  4'd0, 1'b0};
    tbl[17] = '{OP_READ,  4'd2,  4'd0,  4'd0, 1'b1 ^ 1'b1};

    resetn      = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = 2'b00;
    cmd_idx     = 4'd0;
    cmd_src     = 4'd0;
    rsp_ready   = 1'b0;
    sample_tick = 1'b0;
    model_reset();
    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Reset state after a long idle stretch.
    repeat (20) @(posedge clk);
    #1;
    chk_sel("reset");
    chk("reset_cmd_ready", int'(cmd_ready), 1);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_data", int'(rsp_data), 0);
    chk("reset_rsp_err", int'(rsp_err), 0);
    chk("reset_commit_done", int'(commit_done), 0);

    // Vector table: staging, illegal writes/reads, clear.
    for (int i = 0; i < 18; i++) begin
      run_cmd(tbl[i].op, int'(tbl[i].idx), int'(tbl[i].src), 0, 1'b0,
              int'($urandom_range(0, 2)), gd, ge);
      chk($sformatf("tbl%0d_data", i), gd, int'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_err", i), ge, int'(tbl[i].exp_err));
    end
    chk("sel_out3_precommit", int'(sel_out3), 0);
    for (int i = 1; i <= 11; i++) begin
      run_cmd(OP_READ, i, 0, 0, 1'b0, 0, gd, ge);
      chk($sformatf("readback_%0d", i), gd, (i == 3) ? 7 : (i == 11) ? 9 : 0);
    end

    // Commit with the tick five cycles after acceptance.
    run_cmd(OP_COMMIT, 0, 0, 5, 1'b0, 0, gd, ge);
    chk("commit_sel_out3", int'(sel_out3), 7);
    chk("commit_sel_out11", int'(sel_out11), 9);

    // Tick coincident with COMMIT acceptance must not commit.
    run_cmd(OP_WRITE, 4, 2, 0, 1'b0, 0, gd, ge);
    run_cmd(OP_COMMIT, 0, 0, 3, 1'b1, 1, gd, ge);
    chk("coincident_sel_out4", int'(sel_out4), 2);

    // Reset while waiting for a tick discards the commit and any response.
    run_cmd(OP_WRITE, 5, 4, 0, 1'b0, 0, gd, ge);
    cmd_valid = 1'b1;
    cmd_op    = OP_COMMIT;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("wait_rsp_valid", int'(rsp_valid), 0);
    end
    #2 resetn = 1'b0;
    #1;
    model_reset();
    chk_sel("mid_reset");
    chk("mid_reset_rsp_valid", int'(rsp_valid), 0);
    chk("mid_reset_commit_done", int'(commit_done), 0);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_reset_rsp_valid", int'(rsp_valid), 0);
      chk("post_reset_cmd_ready", int'(cmd_ready), 1);
      chk("post_reset_sel_out5", int'(sel_out5), 0);
    end
    run_cmd(OP_READ, 5, 0, 0, 1'b0, 0, gd, ge);
    chk("post_reset_read5", gd, 0);

    // Response back-pressure for ten cycles.
    run_cmd(OP_WRITE, 6, 8, 0, 1'b0, 0, gd, ge);
    run_cmd(OP_READ, 6, 0, 0, 1'b0, 10, gd, ge);
    chk("backpressure_read6", gd, 8);

    // Randomized commands against the model, with stray ticks while idle.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        chk_sel("idle_tick");
      end
      r_op  = int'($urandom_range(0, 3));
      r_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                          : int'($urandom_range(1, 11));
      r_src = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                          : int'($urandom_range(0, 9));
      run_cmd(2'(r_op), r_idx, r_src, int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), gd, ge);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
